// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS core multiply unit.
// Optional build macro used by the multiplier: MULT_EARLY_TERM_EN.
package mips_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_FIX  = 2'd2
  } ms_state_e;

  // Two's-complement magnitude; the most-negative value maps to 2^(W-1).
  function automatic logic [DEF_WIDTH-1:0] abs_val(
    input logic [DEF_WIDTH-1:0] x,
    input logic                 sgn
  );
    return (sgn && x[DEF_WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand latches, accumulator, HI/LO.
// MULT_EARLY_TERM_EN adds a final alignment shift for early exit.
module mult_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
`ifdef MULT_EARLY_TERM_EN
  input  logic             term_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             last_o,
`endif
  input  logic             sign_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod;

  // One shift-add iteration and the signed fix-up of the final product.
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_step = {sum, acc_q[WIDTH-1:1]};
    acc_d    = acc_step;
`ifdef MULT_EARLY_TERM_EN
    if (term_i) begin
      acc_d = acc_step >> (CNT_W'(WIDTH - 1) - cnt_i);
    end
`endif
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

`ifdef MULT_EARLY_TERM_EN
  assign last_o = ~|mplier_q[WIDTH-1:1];
`endif

  // Operand/accumulator registers and committed HI/LO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (load_i) begin
      mcand_q  <= abs_val(srca_i, sign_i);
      mplier_q <= abs_val(srcb_i, sign_i);
      acc_q    <= '0;
      neg_q    <= sign_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
    end else if (fix_i) begin
      {hi_q, lo_q} <= prod;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// Iterative multiply sequencer with HI/LO reads and stall request.
// MULT_EARLY_TERM_EN enables exit once the multiplier runs out of ones.
module mult_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             multstartE,
  input  logic             multsignE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             rdreqM,
  input  logic             lohiM,
  output logic [WIDTH-1:0] multoutM,
  output logic             busy,
  output logic             stallM
);

  ms_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             start_ok;
  logic             load;
  logic             step;
  logic             fix;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULT_EARLY_TERM_EN
  logic             term;
  logic             last;
`endif

  assign start_ok = multstartE & ~flushE;

  // Next state and datapath strobes; a new start always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
`ifdef MULT_EARLY_TERM_EN
    term    = 1'b0;
`endif
    if (start_ok) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = MS_CALC;
`ifdef MULT_EARLY_TERM_EN
      if (~|srcbE) state_d = MS_FIX;
`endif
    end else begin
      unique case (state_q)
        MS_IDLE: state_d = MS_IDLE;
        MS_CALC: begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef MULT_EARLY_TERM_EN
          if (last) begin
            term    = 1'b1;
            state_d = MS_FIX;
          end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MS_FIX;
          end
`else
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MS_FIX;
          end
`endif
        end
        MS_FIX: begin
          fix     = 1'b1;
          state_d = MS_IDLE;
        end
        default: state_d = MS_IDLE;
      endcase
    end
  end

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mult_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (load),
    .step_i (step),
    .fix_i  (fix),
`ifdef MULT_EARLY_TERM_EN
    .term_i (term),
    .cnt_i  (cnt_q),
    .last_o (last),
`endif
    .sign_i (multsignE),
    .srca_i (srcaE),
    .srcb_i (srcbE),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  assign busy     = (state_q != MS_IDLE);
  assign stallM   = rdreqM & busy;
  assign multoutM = lohiM ? hi : lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer against a 64-bit arithmetic model.
// Latency expectations follow MULT_EARLY_TERM_EN when it is defined.
module tb_mult_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         multstartE = 1'b0;
  logic         multsignE = 1'b0;
  logic         flushE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         rdreqM = 1'b0;
  logic         lohiM = 1'b0;
  logic [W-1:0] multoutM;
  logic         busy;
  logic         stallM;

  always #5 clk = ~clk;

  mult_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .multstartE (multstartE),
    .multsignE  (multsignE),
    .flushE     (flushE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .rdreqM     (rdreqM),
    .lohiM      (lohiM),
    .multoutM   (multoutM),
    .busy       (busy),
    .stallM     (stallM)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_tot = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic logic [63:0] ref_prod(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic int ref_lat(
    input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int hb;
    mag = (s && b[31]) ? (~b + 1) : b;
    if (mag == 0) return 1;
    hb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
    return hb + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic f);
    multstartE = 1'b1;
    srcaE      = a;
    srcbE      = b;
    multsignE  = s;
    flushE     = f;
    @(posedge clk);
    #2;
    multstartE = 1'b0;
    flushE     = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 64'(k >= 200), 64'(0));
    @(posedge clk);
    #2;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int extra);
    exp_t e;
    e.prod = ref_prod(a, b, s);
    e.lat  = extra + ref_lat(a, b, s);
    exp_q.push_back(e);
    {m_hi, m_lo} = e.prod;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    push_op(a, b, s, 0);
    drive_start(a, b, s, 1'b0);
    wait_idle();
  endtask

  task automatic restart_op(input logic [31:0] a1, input logic [31:0] b1,
                            input logic s1, input logic [31:0] a2,
                            input logic [31:0] b2, input logic s2,
                            input int off);
    push_op(a2, b2, s2, off);
    drive_start(a1, b1, s1, 1'b0);
    repeat (off - 1) @(posedge clk);
    #2;
    drive_start(a2, b2, s2, 1'b0);
    wait_idle();
  endtask

  task automatic read_chk(input string nm);
    lohiM = 1'b0;
    #1 chk({nm, "_lo"}, 64'(multoutM), 64'(m_lo));
    lohiM = 1'b1;
    #1 chk({nm, "_hi"}, 64'(multoutM), 64'(m_hi));
    lohiM = 1'b0;
  endtask

  // Monitor: each busy-high run that ends outside reset is one commit.
  initial begin
    int   bcnt;
    exp_t e;
    logic sv;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
      end else if (bcnt != 0) begin
        chk("commit_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("busy_cycles", 64'(bcnt), 64'(e.lat));
          sv = lohiM;
          lohiM = 1'b0;
          #1 chk("result_lo", 64'(multoutM), 64'(e.prod[31:0]));
          lohiM = 1'b1;
          #1 chk("result_hi", 64'(multoutM), 64'(e.prod[63:32]));
          lohiM = sv;
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    exp_t        e;
    int          k;
    int          off;
    int          lat1;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a2;
    logic [31:0] b2;
    logic        s;
    logic        s2;
    logic [31:0] corners[4];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;

    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stallM), 64'(0));
    read_chk("rst_out");
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;

    do_op(32'd7, 32'd6, 1'b0);
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    read_chk("after_ops");

    // Read coincident with start, then a read that stalls until FIX.
    push_op(32'h0001_2345, 32'h0000_0055, 1'b0, 0);
    e = exp_q[exp_q.size()-1];
    multstartE = 1'b1;
    srcaE      = 32'h0001_2345;
    srcbE      = 32'h0000_0055;
    multsignE  = 1'b0;
    rdreqM     = 1'b1;
    lohiM      = 1'b0;
    @(negedge clk);
    chk("coinc_stall", 64'(stallM), 64'(0));
    chk("coinc_old_lo", 64'(multoutM), 64'(32'h0));
    @(posedge clk);
    #2;
    multstartE = 1'b0;
    rdreqM     = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rdreqM = 1'b1;
    lohiM  = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      chk("stall_busy", 64'(stallM), 64'(1));
    end
    chk("stall_release", 64'(stallM), 64'(0));
    chk("read_new_lo", 64'(multoutM), 64'(e.prod[31:0]));
    @(posedge clk);
    #2;
    rdreqM = 1'b0;

    // Abort and restart: only the second product may commit.
    lat1 = ref_lat(32'd2, 32'd3, 1'b0);
    off  = (lat1 < 10) ? lat1 : 10;
    restart_op(32'd2, 32'd3, 1'b0, 32'd4, 32'd5, 1'b0, off);
    read_chk("restart");

    // Flushed start while idle changes nothing.
    drive_start(32'd11, 32'd13, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #2;
    read_chk("flush_idle");

    // Flushed start while busy does not disturb the running op.
    push_op(32'h0000_1234, 32'h00F0_0000, 1'b0, 0);
    drive_start(32'h0000_1234, 32'h00F0_0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    drive_start(32'd99, 32'd77, 1'b1, 1'b1);
    wait_idle();

    // Reset in the middle of an operation.
    drive_start(32'h1111, 32'h2222, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    #1 chk("midrst_busy", 64'(busy), 64'(0));
    m_hi = '0;
    m_lo = '0;
    read_chk("midrst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    do_op(32'd9, 32'd9, 1'b0);
    chk("nine_sq", 64'(m_lo), 64'(81));

    // Randomized operations, some aborted by a later start.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = b & 32'hFF;
        1: b = corners[$urandom_range(0, 3)];
        2: a = corners[$urandom_range(0, 3)];
        default: ;
      endcase
      lat1 = ref_lat(a, b, s);
      if ($urandom_range(0, 3) == 0 && lat1 > 1) begin
        a2  = $urandom;
        b2  = $urandom;
        s2  = 1'($urandom_range(0, 1));
        off = $urandom_range(1, lat1);
        restart_op(a, b, s, a2, b2, s2, off);
      end else begin
        do_op(a, b, s);
      end
    end
    read_chk("final");

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
